// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: control/address bundle between the NTT sequencer and its memory/BFU path.
interface ntt_ctrl_if #(parameter int LOGN = 8);
  logic i_start, i_intt, i_algo, i_copy;
  logic o_busy, o_done, o_rd_en, o_wr_en;
  logic o_bfu_intt, o_bfu_algo, o_bfu_skip;
  logic [LOGN-1:0] o_rd_addr_a, o_rd_addr_b, o_tw_addr, o_wr_addr_a, o_wr_addr_b;
  modport master (
    output i_start, i_intt, i_algo, i_copy,
    input  o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_bfu_intt, o_bfu_algo, o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
  modport slave (
    input  i_start, i_intt, i_algo, i_copy,
    output o_busy, o_done, o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
           o_bfu_intt, o_bfu_algo, o_bfu_skip, o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: walks the NTT/INTT butterfly schedule, issuing pair/twiddle reads and
// LAT-delayed write-backs with drain bubbles between layers.
module ntt_ctrl #(
  parameter int N       = 256,
  parameter int LOGN    = 8,
  parameter int MEM_LAT = 1,
  parameter int BFU_LAT = 4
) (
  input logic      i_clk,
  input logic      i_rst,
  ntt_ctrl_if.slave bus
);
  localparam int LAT = MEM_LAT + BFU_LAT;
  localparam int SW  = $clog2(LOGN);
  localparam int DW  = $clog2(LAT + 1);
  localparam logic [SW-1:0]   SH_MAX   = SW'(LOGN - 1);
  localparam logic [SW-1:0]   SH_ONE   = SW'(1);
  localparam logic [LOGN-2:0] CNT_ONE  = (LOGN-1)'(1);
  localparam logic [LOGN-2:0] CNT_LAST = '1;
  localparam logic [DW-1:0]   D_LAST   = DW'(LAT - 1);
  localparam logic [DW-1:0]   D_ONE    = DW'(1);
  localparam logic [LOGN-1:0] A_ONE    = LOGN'(1);
  localparam logic [LOGN-1:0] HALF     = LOGN'(N / 2);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state_q;
  logic [SW-1:0] sh_q, sh_d, first_sh, next_sh;
  logic [LOGN-2:0] cnt_q, cnt_d;
  logic [DW-1:0] dcnt_q;
  logic intt_q, algo_q, skip_q, busy_q, done_q, rd_en_q;
  logic [LOGN-1:0] rd_a_q, rd_b_q, tw_q, a_d, b_d, tw_d, msk, blk, m, c_ext;
  logic intt_m, skip_m, last_layer, drain_end, issue;
  logic dv_q [LAT];
  logic [LOGN-1:0] da_q [LAT];
  logic [LOGN-1:0] db_q [LAT];
  // sh is log2(len); a = block*2len + offset, twiddle k = m+blk (NTT) or 2m-1-blk (INTT)
  always_comb begin
    skip_m     = state_q == IDLE ? bus.i_copy : skip_q;
    intt_m     = state_q == IDLE ? bus.i_intt & ~bus.i_copy : intt_q;
    first_sh   = (bus.i_intt & ~bus.i_copy) ? {{(SW-1){1'b0}}, ~bus.i_algo} : SH_MAX;
    next_sh    = intt_q ? sh_q + SH_ONE : sh_q - SH_ONE;
    last_layer = skip_q | (intt_q ? sh_q == SH_MAX : sh_q == {{(SW-1){1'b0}}, ~algo_q});
    drain_end  = state_q == DRAIN && dcnt_q == D_LAST;
    issue      = (state_q == IDLE && bus.i_start) || (state_q == ISSUE && cnt_q != CNT_LAST) ||
                 (drain_end && !last_layer);
    sh_d       = state_q == IDLE ? first_sh : drain_end ? next_sh : sh_q;
    cnt_d      = state_q == ISSUE ? cnt_q + CNT_ONE : '0;
    c_ext      = LOGN'(cnt_d);
    msk        = (A_ONE << sh_d) - A_ONE;
    a_d        = ((c_ext & ~msk) << 1) | (c_ext & msk);
    b_d        = a_d + (A_ONE << sh_d);
    blk        = c_ext >> sh_d;
    m          = HALF >> sh_d;
    tw_d       = skip_m ? '0 : intt_m ? (m << 1) - A_ONE - blk : m + blk;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      intt_q  <= 1'b0;
      algo_q  <= 1'b0;
      skip_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= state_q == DRAIN ? dcnt_q + D_ONE : '0;
      done_q  <= 1'b0;
      rd_en_q <= issue;
      if (issue) begin
        rd_a_q <= a_d;
        rd_b_q <= b_d;
        tw_q   <= tw_d;
      end
      case (state_q)
        IDLE: if (bus.i_start) begin
          state_q <= ISSUE;
          intt_q  <= bus.i_intt & ~bus.i_copy;
          algo_q  <= bus.i_algo;
          skip_q  <= bus.i_copy;
          busy_q  <= 1'b1;
        end
        ISSUE: if (cnt_q == CNT_LAST) state_q <= DRAIN;
        DRAIN: if (drain_end) begin
          state_q <= last_layer ? FIN : ISSUE;
          done_q  <= last_layer;
          busy_q  <= ~last_layer;
        end
        FIN: begin
          state_q <= IDLE;
          intt_q  <= 1'b0;
          algo_q  <= 1'b0;
          skip_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // write-back delay line keeps shifting through DRAIN and IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LAT; i++) begin
        dv_q[i] <= 1'b0;
        da_q[i] <= '0;
        db_q[i] <= '0;
      end
    end else begin
      dv_q[0] <= rd_en_q;
      da_q[0] <= rd_a_q;
      db_q[0] <= rd_b_q;
      for (int i = 1; i < LAT; i++) begin
        dv_q[i] <= dv_q[i-1];
        da_q[i] <= da_q[i-1];
        db_q[i] <= db_q[i-1];
      end
    end
  end
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_rd_addr_a = rd_a_q;
  assign bus.o_rd_addr_b = rd_b_q;
  assign bus.o_tw_addr   = tw_q;
  assign bus.o_bfu_intt  = intt_q;
  assign bus.o_bfu_algo  = algo_q;
  assign bus.o_bfu_skip  = skip_q;
  assign bus.o_wr_en     = dv_q[LAT-1];
  assign bus.o_wr_addr_a = da_q[LAT-1];
  assign bus.o_wr_addr_b = db_q[LAT-1];
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: table-driven runs of every transform mode against a loop-built
// schedule model, plus a hand-written reset-abort sequence.
module tb_ntt_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  ntt_ctrl_if #(.LOGN(8)) bus ();
  ntt_ctrl dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string name;
    int copy, intt, algo, poke, n_iss, done_cyc;
    int fa, fb, ft, sa, sb, st, la, lb, lt;
  } vec_t;
  typedef struct { int a, b, tw; } iss_t;
  iss_t exp_q[$];
  logic hen [4096];
  int   ha [4096];
  int   hb [4096];
  int   last_rd [256];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic build(input int copy, input int intt, input int algo);
    int k;
    exp_q.delete();
    if (copy != 0) begin
      for (int j = 0; j < 128; j++) exp_q.push_back('{j, j + 128, 0});
    end else if (intt == 0) begin
      k = 0;
      for (int len = 128; len >= (algo != 0 ? 1 : 2); len = len / 2)
        for (int s = 0; s < 256; s += 2 * len) begin
          k++;
          for (int j = s; j < s + len; j++) exp_q.push_back('{j, j + len, k});
        end
    end else begin
      k = (algo != 0) ? 256 : 128;
      for (int len = (algo != 0 ? 1 : 2); len <= 128; len = len * 2)
        for (int s = 0; s < 256; s += 2 * len) begin
          k--;
          for (int j = s; j < s + len; j++) exp_q.push_back('{j, j + len, k});
        end
    end
  endtask
  function automatic logic [46:0] outs();
    return {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rd_addr_a, bus.o_rd_addr_b, bus.o_tw_addr,
            bus.o_bfu_intt, bus.o_bfu_algo, bus.o_bfu_skip, bus.o_wr_en, bus.o_wr_addr_a, bus.o_wr_addr_b};
  endfunction
  task automatic run(input vec_t v);
    int cyc, idx, done_at, sched_err, wr_err, haz, busy_err, dpulses, ea, eb;
    iss_t first, sec, last;
    logic ew;
    build(v.copy, v.intt, v.algo);
    for (int i = 0; i < 256; i++) last_rd[i] = -100;
    for (int i = 0; i < 4096; i++) hen[i] = 1'b0;
    first = '{-1, -1, -1}; sec = first; last = first;
    {cyc, idx, sched_err, wr_err, haz, busy_err, dpulses} = '0;
    done_at = -1;
    @(negedge clk);
    chk({v.name, " idle"}, {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_bfu_intt, bus.o_bfu_algo,
        bus.o_bfu_skip, bus.o_wr_en}, 7'd0);
    bus.i_copy = v.copy[0]; bus.i_intt = v.intt[0]; bus.i_algo = v.algo[0]; bus.i_start = 1'b1;
    while (done_at < 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.i_start = (cyc == v.poke);
      bus.i_copy = ~v.copy[0]; bus.i_intt = ~v.intt[0]; bus.i_algo = ~v.algo[0];
      if (cyc == 1)
        chk({v.name, " bfu_modes"}, {bus.o_bfu_intt, bus.o_bfu_algo, bus.o_bfu_skip},
            {v.intt[0] & ~v.copy[0], v.algo[0], v.copy[0]});
      hen[cyc] = bus.o_rd_en; ha[cyc] = int'(bus.o_rd_addr_a); hb[cyc] = int'(bus.o_rd_addr_b);
      if (bus.o_rd_en) begin
        ea = int'(bus.o_rd_addr_a); eb = int'(bus.o_rd_addr_b);
        if (idx >= exp_q.size() || exp_q[idx].a != ea || exp_q[idx].b != eb ||
            exp_q[idx].tw != int'(bus.o_tw_addr)) sched_err++;
        if (cyc - last_rd[ea] <= 5 || cyc - last_rd[eb] <= 5) haz++;
        last_rd[ea] = cyc; last_rd[eb] = cyc;
        if (idx == 0) first = '{ea, eb, int'(bus.o_tw_addr)};
        if (idx == 128) sec = '{ea, eb, int'(bus.o_tw_addr)};
        last = '{ea, eb, int'(bus.o_tw_addr)};
        idx++;
      end
      ew = (cyc > 5) ? hen[cyc-5] : 1'b0;
      if (bus.o_wr_en !== ew || (ew && (int'(bus.o_wr_addr_a) != ha[cyc-5] ||
          int'(bus.o_wr_addr_b) != hb[cyc-5]))) wr_err++;
      if (bus.o_busy !== !bus.o_done) busy_err++;
      if (bus.o_done) begin dpulses++; done_at = cyc; end
    end
    bus.i_start = 1'b0;
    chk({v.name, " done_cycle"}, done_at, v.done_cyc);
    chk({v.name, " issue_count"}, idx, v.n_iss);
    chk({v.name, " first_issue"}, {first.a, first.b, first.tw}, {v.fa, v.fb, v.ft});
    if (v.n_iss > 128)
      chk({v.name, " issue_129"}, {sec.a, sec.b, sec.tw}, {v.sa, v.sb, v.st});
    chk({v.name, " last_issue"}, {last.a, last.b, last.tw}, {v.la, v.lb, v.lt});
    chk({v.name, " schedule_errs"}, sched_err, 0);
    chk({v.name, " writeback_errs"}, wr_err, 0);
    chk({v.name, " hazards"}, haz, 0);
    chk({v.name, " busy_errs"}, busy_err, 0);
    chk({v.name, " done_pulses"}, dpulses, 1);
  endtask
  vec_t tbl [5];
  initial begin
    int dn, bz;
    tbl[0] = '{"dil_ntt",  0, 0, 1, 300, 1024, 1065, 0, 128, 1,   0, 64, 2,   254, 255, 255};
    tbl[1] = '{"kyb_intt", 0, 1, 0, 0,   896,  932,  0, 2,   127, 0, 4,  63,  127, 255, 1};
    tbl[2] = '{"copy",     1, 1, 0, 50,  128,  134,  0, 128, 0,   0, 0,  0,   127, 255, 0};
    tbl[3] = '{"kyb_ntt",  0, 0, 0, 600, 896,  932,  0, 128, 1,   0, 64, 2,   253, 255, 127};
    tbl[4] = '{"dil_intt", 0, 1, 1, 0,   1024, 1065, 0, 1,   255, 0, 2,  127, 127, 255, 1};
    bus.i_start = 1'b0; bus.i_intt = 1'b0; bus.i_algo = 1'b0; bus.i_copy = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 47'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.i_algo = 1'b1; bus.i_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.i_start = 1'b0;
    end
    chk("abort_mid_issue", bus.o_rd_en, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_outputs", outs(), 47'd0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0; bz = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.o_done) dn++;
      if (bus.o_busy) bz++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_busy", bz, 0);
    for (int t = 0; t < 5; t++) run(tbl[t]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
